// File: rtl/xc_aessub_seq_pkg.sv
// Shared AES definitions for the xc_aes* units: FSM encodings, field constants,
// operand lane mapping and GF(2^8) helper functions.
package xc_aes_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] AES_POLY     = 8'h1b;
    localparam logic [7:0] AFFINE_C     = 8'h63;
    localparam logic [7:0] INV_AFFINE_C = 8'h05;
    localparam int         LANE_W       = 8;
    // Lanes 0-1 come from rs1, lanes 2-3 from rs2, at their natural bit positions.
    localparam int         RS1_LANES    = 2;

    function automatic logic [7:0] lane_byte(input logic [31:0] rs1, input logic [31:0] rs2,
                                             input int lane);
        return (lane < RS1_LANES) ? rs1[lane*LANE_W +: LANE_W] : rs2[lane*LANE_W +: LANE_W];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = x[(i + 8 - n) % 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse for x != 0 and yields 0 for x == 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ AFFINE_C;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/xc_aessub_seq_if.sv
// Core <-> SubBytes unit handshake bundle: hold-until-ready request, gated result.
interface xc_aessub_seq_if;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        ready;
    logic [31:0] result;

    modport master (output valid, rs1, rs2, enc, input ready, result);
    modport slave  (input valid, rs1, rs2, enc, output ready, result);
endinterface

// File: rtl/xc_aessub_sbox.sv
// Combinational AES S-box: enc=1 forward (GF inverse then affine), enc=0 inverse.
module xc_aessub_sbox
    import xc_aes_defs::*;
(
    input  logic [7:0] byte_val,
    input  logic       enc,
    output logic [7:0] sub_val
);
    logic [7:0] inv_in;
    logic [7:0] inv_out;

    // The GF inverse is shared by both directions; only the affine step moves.
    always_comb begin
        inv_in  = enc ? byte_val : inv_affine(byte_val);
        inv_out = gf_inv(inv_in);
        sub_val = enc ? affine(inv_out) : inv_out;
    end
endmodule

// File: rtl/xc_aessub_seq.sv
// AES SubBytes/InvSubBytes unit, one shared S-box, one byte per cycle.
// Define XC_AESSUB_PARALLEL_EN for the four-S-box single-cycle combinational build.
module xc_aessub_seq
    import xc_aes_defs::*;
#(
    parameter int NBYTES = 4
) (
    input  logic          clock,
    input  logic          reset,
    xc_aessub_seq_if.slave bus
);
`ifdef XC_AESSUB_PARALLEL_EN
    logic [31:0] sub_word;
    logic        unused_clk_rst;

    assign unused_clk_rst = clock ^ reset;

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_sbox
        xc_aessub_sbox u_sbox (
            .byte_val (lane_byte(bus.rs1, bus.rs2, gi)),
            .enc      (bus.enc),
            .sub_val  (sub_word[gi*LANE_W +: LANE_W])
        );
    end

    assign bus.ready  = bus.valid;
    assign bus.result = sub_word & {32{bus.valid}};
`else
    localparam int                CNT_W    = $clog2(NBYTES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NBYTES - 1);

    state_t                       state_reg;
    logic [CNT_W-1:0]             cnt_reg;
    logic [NBYTES-1:0][7:0]       lane_reg;
    logic                         enc_reg;
    logic [31:0]                  result_reg;
    logic                         ready_reg;
    logic [7:0]                   sbox_out;

    xc_aessub_sbox u_sbox (
        .byte_val (lane_reg[cnt_reg]),
        .enc      (enc_reg),
        .sub_val  (sbox_out)
    );

    // Dropping valid in RUN or DONE aborts and discards the partial result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            lane_reg   <= '0;
            enc_reg    <= 1'b0;
            result_reg <= '0;
            ready_reg  <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.valid) begin
                        for (int k = 0; k < NBYTES; k++) begin
                            lane_reg[k] <= lane_byte(bus.rs1, bus.rs2, k);
                        end
                        enc_reg    <= bus.enc;
                        result_reg <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!bus.valid) begin
                        cnt_reg    <= '0;
                        result_reg <= '0;
                        state_reg  <= ST_IDLE;
                    end else begin
                        result_reg[{cnt_reg, 3'b000} +: LANE_W] <= sbox_out;
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= ST_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                    if (bus.valid) begin
                        ready_reg <= 1'b1;
                    end else begin
                        result_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = ready_reg;
    assign bus.result = result_reg & {32{ready_reg}};
`endif
endmodule

// File: tb/tb_xc_aessub_seq.sv
// Scoreboard bench for xc_aessub_seq: directed vectors plus a full S-box sweep.
module tb_xc_aessub_seq;

`ifdef XC_AESSUB_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 6;
`endif

    typedef struct {
        logic [31:0] result;
        int          due;
        string       name;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t expq[$];
    exp_t mon_e;

    logic [7:0] sbox_tab [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] inv_tab [0:255];

    xc_aessub_seq_if bus ();

    xc_aessub_seq #(.NBYTES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pops an expectation on every ready, otherwise demands a zero bus.
    always @(negedge clock) begin
        if (expq.size() > 0 && cyc > expq[0].due && bus.ready !== 1'b1) begin
            mon_e = expq.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missed_ready: no ready by cyc=%0d, required at cyc=%0d", mon_e.name, cyc, mon_e.due);
        end
        if (bus.ready === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready cyc=%0d result=%08h, required no ready", cyc, bus.result);
            end else begin
                mon_e = expq.pop_front();
                if (bus.result !== mon_e.result || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL %s result=%08h cyc=%0d, required result=%08h cyc=%0d",
                             mon_e.name, bus.result, cyc, mon_e.result, mon_e.due);
                end else begin
                    $display("txn %s result=%08h cyc=%0d ok", mon_e.name, bus.result, cyc);
                end
            end
        end else begin
            checks++;
            if (bus.ready !== 1'b0 || bus.result !== 32'h0) begin
                errors++;
                $display("FAIL idle_bus cyc=%0d ready=%b result=%08h, required ready=0 result=00000000",
                         cyc, bus.ready, bus.result);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic drive(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic e, input logic [31:0] res, input bit expect_it);
        bus.rs1   = a;
        bus.rs2   = b;
        bus.enc   = e;
        bus.valid = 1'b1;
        if (expect_it) expq.push_back('{res, cyc + LAT, name});
    endtask

    // Returns at negedge+1 of the cycle ready was seen, valid still high.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.ready !== 1'b1 && n < 20);
        if (bus.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: ready=%b after %0d cycles, required ready=1", name, bus.ready, n);
        end
        #1;
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic e, input logic [31:0] res);
        drive(name, a, b, e, res, 1'b1);
        wait_ready(name);
        bus.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] l0, l1, l2, l3;
        for (int i = 0; i < 256; i++) inv_tab[sbox_tab[i]] = 8'(i);
        reset     = 1'b1;
        bus.valid = 1'b0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        bus.enc   = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_ready", {31'b0, bus.ready}, 32'h0);
        check("reset_result", bus.result, 32'h0);
        #1 reset = 1'b0;
        idle(2);

        run_op("enc", 32'hAAAA5300, 32'hFF01BBBB, 1'b1, 32'h167CED63);
        idle(2);
        run_op("dec", 32'h0000ED63, 32'h167C0000, 1'b0, 32'hFF015300);
        idle(2);

`ifndef XC_AESSUB_PARALLEL_EN
        // Abort in RUN, then in DONE: neither may produce a pulse.
        drive("abort_run", 32'hAAAA5300, 32'hFF01BBBB, 1'b1, 32'h0, 1'b0);
        idle(2);
        bus.valid = 1'b0;
        idle(8);
        run_op("dec_after_abort", 32'h0000ED63, 32'h167C0000, 1'b0, 32'hFF015300);
        idle(2);
        drive("abort_done", 32'hAAAA5300, 32'hFF01BBBB, 1'b1, 32'h0, 1'b0);
        idle(5);
        bus.valid = 1'b0;
        idle(8);

        // Reset while RUN is on byte 2.
        drive("reset_mid", 32'hAAAA5300, 32'hFF01BBBB, 1'b1, 32'h0, 1'b0);
        idle(3);
        reset     = 1'b1;
        bus.valid = 1'b0;
        @(negedge clock);
        check("reset_mid_ready", {31'b0, bus.ready}, 32'h0);
        check("reset_mid_result", bus.result, 32'h0);
        #1 reset = 1'b0;
        idle(8);
        run_op("enc_after_reset", 32'hAAAA5300, 32'hFF01BBBB, 1'b1, 32'h167CED63);
        idle(2);
`endif

        // Back-to-back: valid stays high, operands swap right after ready.
        drive("b2b_enc", 32'hAAAA5300, 32'hFF01BBBB, 1'b1, 32'h167CED63, 1'b1);
        wait_ready("b2b_enc");
        drive("b2b_dec", 32'h0000ED63, 32'h167C0000, 1'b0, 32'hFF015300, 1'b1);
        wait_ready("b2b_dec");
        bus.valid = 1'b0;
        idle(2);

        // Full sweep; unused operand bits carry junk that must be ignored.
        for (int x = 0; x < 256; x++) begin
            l0 = 8'(x);
            l1 = 8'(x) ^ 8'h5a;
            l2 = 8'(x + 1);
            l3 = ~8'(x);
            run_op("sweep_enc", {16'hDEAD, l1, l0}, {l3, l2, 16'hBEEF}, 1'b1,
                   {sbox_tab[l3], sbox_tab[l2], sbox_tab[l1], sbox_tab[l0]});
            run_op("sweep_dec", {16'hC0DE, l1, sbox_tab[l0]}, {l3, l2, 16'hF00D}, 1'b0,
                   {inv_tab[l3], inv_tab[l2], inv_tab[l1], l0});
        end

        idle(10);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations left=%0d required=0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
